// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: sequences ALU, unified
// memory and register file, stalls on mem_ready, halts on unsupported encodings.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12, S_HALT   = 4'd13
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t     state, state_nxt;
  logic       funct_ok;
  logic [3:0] funct_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'b100011, 6'b101011: state_nxt = S_MEMADR;
          6'b000000:            state_nxt = funct_ok ? S_EXEC : S_HALT;
          6'b000100:            state_nxt = S_BRANCH;
          6'b001000:            state_nxt = S_ADDIEX;
          6'b000010:            state_nxt = S_JUMP;
          default:              state_nxt = S_HALT;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ALUWB:  state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_ADDIEX: state_nxt = S_ADDIWB;
      S_ADDIWB: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_HALT;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 4'b0000;
    pc_source   = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_source   = 2'b01;
        pc_en       = zero;
        instr_done  = 1'b1;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: the driver pushes the expected output vector for each cycle,
// and a negedge monitor pops it and compares it with the sampled DUT outputs.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_control, state_o;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [1:0] pc_source;
    logic       instr_done, illegal;
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   stepno = 0;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_source(pc_source),
    .instr_done(instr_done), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] RST = 0, FET = 1, DEC = 2, MAD = 3, MRD = 4, MWB = 5,
                         MWR = 6, EXE = 7, AWB = 8, BRA = 9, AEX = 10, AWBI = 11,
                         JMP = 12, HLT = 13;

  // Expected outputs for a given state, written from the per-state output table.
  function automatic obs_t exp_out(input logic [3:0] st, input logic mr,
                                   input logic z, input logic [5:0] fn);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      FET: begin e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_control = 4'b0010;
                 e.ir_write = mr; e.pc_en = mr; end
      DEC: begin e.alu_src_b = 2'b11; e.alu_control = 4'b0010; end
      MAD, AEX: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 4'b0010; end
      MRD: begin e.iord = 1; e.mem_read = 1; end
      MWB: begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      MWR: begin e.iord = 1; e.mem_write = 1; e.instr_done = mr; end
      EXE: begin
        e.alu_src_a = 1;
        case (fn)
          6'b100010: e.alu_control = 4'b0110;
          6'b100100: e.alu_control = 4'b0000;
          6'b100101: e.alu_control = 4'b0001;
          6'b101010: e.alu_control = 4'b0111;
          default:   e.alu_control = 4'b0010;
        endcase
      end
      AWB:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
      BRA:  begin e.alu_src_a = 1; e.alu_control = 4'b0110; e.pc_source = 2'b01;
                  e.pc_en = z; e.instr_done = 1; end
      AWBI: begin e.reg_write = 1; e.instr_done = 1; end
      JMP:  begin e.pc_source = 2'b10; e.pc_en = 1; e.instr_done = 1; end
      HLT:  e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  // One cycle: drive inputs just after the edge, then queue what this cycle must show.
  task automatic step(input logic r, input logic mr, input logic z, input logic [3:0] st);
    @(posedge clk);
    #1;
    rst_n = r;
    mem_ready = mr;
    zero = z;
    q.push_back(exp_out(st, mr, z, funct));
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      obs_t e, a;
      e = q.pop_front();
      a = '{st: state_o, pc_en: pc_en, iord: iord, mem_read: mem_read,
            mem_write: mem_write, ir_write: ir_write, reg_write: reg_write,
            reg_dst: reg_dst, mem_to_reg: mem_to_reg, alu_src_a: alu_src_a,
            alu_src_b: alu_src_b, alu_control: alu_control, pc_source: pc_source,
            instr_done: instr_done, illegal: illegal};
      checks++;
      stepno++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_%0d state got=%0d exp=%0d outputs got=%h exp=%h",
                 stepno, a.st, e.st, a, e);
      end
    end
  end

  initial begin
    logic [5:0] fns[4];
    fns[0] = 6'b100000; fns[1] = 6'b100100; fns[2] = 6'b100101; fns[3] = 6'b101010;

    // Reset state, then release: R-type sub
    opcode = 6'b000000; funct = 6'b100010;
    step(0, 1, 0, RST);
    step(0, 1, 0, RST);
    step(1, 1, 0, RST);
    step(1, 1, 0, FET);
    step(1, 1, 0, DEC);
    step(1, 1, 0, EXE);
    step(1, 1, 0, AWB);

    // Remaining R-type functs, with one FETCH stall on the first
    foreach (fns[i]) begin
      funct = fns[i];
      if (i == 0) step(1, 0, 0, FET);
      step(1, 1, 0, FET);
      step(1, 1, 0, DEC);
      step(1, 0, 1, EXE);
      step(1, 0, 1, AWB);
    end

    // lw with two MEMRD wait cycles
    opcode = 6'b100011;
    step(1, 1, 0, FET);
    step(1, 0, 0, DEC);
    step(1, 0, 0, MAD);
    step(1, 0, 0, MRD);
    step(1, 0, 0, MRD);
    step(1, 1, 0, MRD);
    step(1, 0, 0, MWB);

    // beq taken, then not taken
    opcode = 6'b000100;
    step(1, 1, 0, FET);
    step(1, 1, 0, DEC);
    step(1, 1, 1, BRA);
    step(1, 1, 0, FET);
    step(1, 1, 1, DEC);
    step(1, 1, 0, BRA);

    // j, then addi
    opcode = 6'b000010;
    step(1, 1, 0, FET);
    step(1, 1, 0, DEC);
    step(1, 1, 0, JMP);
    opcode = 6'b001000;
    step(1, 1, 0, FET);
    step(1, 1, 0, DEC);
    step(1, 1, 0, AEX);
    step(1, 1, 0, AWBI);

    // sw completing normally with one wait
    opcode = 6'b101011;
    step(1, 1, 0, FET);
    step(1, 1, 0, DEC);
    step(1, 1, 0, MAD);
    step(1, 0, 0, MWR);
    step(1, 1, 0, MWR);

    // Illegal opcode: halts regardless of mem_ready/zero, reset recovers
    opcode = 6'b111111;
    step(1, 1, 0, FET);
    step(1, 1, 0, DEC);
    for (int k = 0; k < 11; k++) step(1, k[0], k[1], HLT);
    step(0, 1, 0, RST);
    step(1, 1, 0, RST);

    // R-type with unsupported funct
    opcode = 6'b000000; funct = 6'b000000;
    step(1, 1, 0, FET);
    step(1, 1, 0, DEC);
    for (int k = 0; k < 10; k++) step(1, k[1], k[0], HLT);
    step(0, 1, 0, RST);
    step(1, 1, 0, RST);

    // sw with reset dropped mid-MEMWR
    opcode = 6'b101011; funct = 6'b100000;
    step(1, 1, 0, FET);
    step(1, 1, 0, DEC);
    step(1, 0, 0, MAD);
    step(1, 0, 0, MWR);
    step(1, 0, 0, MWR);
    step(0, 1, 0, RST);
    step(0, 1, 0, RST);
    step(1, 1, 0, RST);
    step(1, 1, 0, FET);
    step(1, 1, 0, DEC);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control unit for the multicycle MIPS datapath. A Moore-style FSM sequences one shared ALU, one unified instruction/data memory and the register file over several cycles per instruction. It drives every datapath select and enable, including the 4-bit `alu_control` code of the ALU. It stalls on a memory ready handshake and halts on unsupported encodings.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: IR[31:26]. Stable from DECODE until the next FETCH.
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_en` output 1: PC load enable.
- `iord` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write`, `reg_write` output 1 each: strobes.
- `reg_dst` output 1: write-register select; 0 = rt, 1 = rd.
- `mem_to_reg` output 1: write-back select; 0 = ALUOut, 1 = MDR.
- `alu_src_a` output 1: 0 = PC, 1 = A register.
- `alu_src_b` output 2: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_control` output 4: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- `pc_source` output 2: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}.
- `instr_done` output 1: pulse in the last cycle of each retired instruction.
- `illegal` output 1: high while in HALT.
- `state_o` output 4: current state encoding (debug).

## Operation
- State encodings: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, HALT=13. Encodings 14 and 15 go to HALT.
- Outputs decode from the state only, except `pc_en`, `ir_write` and `instr_done`, which are also gated by `mem_ready`/`zero` as listed. Any output not listed for a state is 0.
- RESET: all outputs 0. Goes to FETCH.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_source`=00. `ir_write`=`pc_en`=`mem_ready`. Goes to DECODE when `mem_ready`=1, otherwise holds.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 → EXEC if funct ∈ {100000, 100010, 100100, 100101, 101010}, else HALT.
  - 000100 (beq) → BRANCH.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JUMP.
  - Any other opcode → HALT.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1, `mem_read`=1. Holds until `mem_ready`=1, then goes to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Goes to FETCH.
- MEMWR: `iord`=1, `mem_write`=1, `instr_done`=`mem_ready`. Holds until `mem_ready`=1, then goes to FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00. `alu_control` from funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111. Goes to ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_source`=01, `pc_en`=`zero`, `instr_done`=1. Goes to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, add. Goes to ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Goes to FETCH.
- JUMP: `pc_source`=10, `pc_en`=1, `instr_done`=1. Goes to FETCH.
- HALT: all strobes 0, `illegal`=1. Leaves only on reset.

## Timing
- State register updates on the rising edge of `clk`. `rst_n`=0 forces RESET immediately and asynchronously, so all outputs are 0 within the same cycle, including mid-instruction. A pending memory write is dropped.
- The first FETCH occurs in the cycle after the first edge with `rst_n`=1.
- Cycles per instruction with `mem_ready` tied to 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3. Each wait cycle in FETCH, MEMRD or MEMWR adds 1.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- While waiting, `mem_read`/`mem_write` and the address select stay asserted and stable. `pc_en` and `ir_write` stay 0.
- `instr_done` is high for exactly one cycle per instruction, never in HALT.

## Test plan
- Reset released, `mem_ready`=1, opcode 000000, funct 100010: `state_o` goes 0,1,2,7,8,1. EXEC drives `alu_control`=0110. ALUWB drives `reg_write`=1, `reg_dst`=1. One `instr_done` pulse.
- lw (100011) with `mem_ready` low for 2 cycles in MEMRD: 7 cycles from FETCH to the next FETCH. `mem_read`=`iord`=1 through all three MEMRD cycles. MEMWB drives `mem_to_reg`=1.
- beq with `zero`=1, then with `zero`=0: BRANCH drives `pc_en`=1 in the first case and 0 in the second. Both drive `pc_source`=01, `alu_control`=0110. 3 cycles each.
- j, then addi: JUMP drives `pc_en`=1, `pc_source`=10. addi drives `alu_src_b`=10 in ADDIEX and `reg_dst`=0 in ADDIWB.
- Opcode 111111, and R-type funct 000000: both go DECODE→HALT. `illegal`=1 and all strobes 0 for 10+ cycles. `rst_n` pulse returns to RESET, then FETCH.
- sw with `rst_n` dropped mid-MEMWR: `mem_write` falls in the same cycle. `state_o`=0 until release.
